// File: rtl/imuldiv_mul_pkg.sv
// Shared definitions for the iterative multiplier: request modes, FSM state
// encoding and operand conditioning helpers.
package imuldiv_mul_pkg;

    localparam logic [1:0] MUL_MODE_UU = 2'b00;
    localparam logic [1:0] MUL_MODE_SS = 2'b01;
    localparam logic [1:0] MUL_MODE_SU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    function automatic logic mul_a_is_signed(input logic [1:0] mode);
        return (mode == MUL_MODE_SS) || (mode == MUL_MODE_SU);
    endfunction

    function automatic logic mul_b_is_signed(input logic [1:0] mode);
        return (mode == MUL_MODE_SS);
    endfunction

    // Returns {negative, magnitude}; caller keeps the low `width` bits of the
    // magnitude, so the most negative value maps to 2^(width-1).
    function automatic logic [64:0] mul_operand_cond(input logic [63:0] val,
                                                     input int unsigned width,
                                                     input logic is_signed);
        logic        neg;
        logic [63:0] mag;
        neg = is_signed && (((val >> (width - 1)) & 64'd1) != 64'd0);
        mag = neg ? (~val + 64'd1) : val;
        return {neg, mag};
    endfunction

endpackage

// File: rtl/imuldiv_int_mul_iter_param_ctrl.sv
// Control FSM and iteration counter for the iterative multiplier.
// Honors IMULDIV_MUL_EARLY_TERM_EN to leave CALC once the multiplier is exhausted.
//
// state | meaning
// IDLE  | ready for a request, operands latched on handshake
// CALC  | one shift-add iteration per cycle
// DONE  | product valid, held until the response handshake
module imuldiv_int_mul_iter_param_ctrl
    import imuldiv_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic mulreq_val,
    output logic mulreq_rdy,
    output logic mulresp_val,
    input  logic mulresp_rdy,
    input  logic b_lsb,
    input  logic b_next_zero,
    output logic operand_ld,
    output logic shift_en,
    output logic add_en
);

    mul_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;

`ifdef IMULDIV_MUL_EARLY_TERM_EN
    assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || b_next_zero;
`else
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    logic unused_b_next_zero;
    assign unused_b_next_zero = b_next_zero;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (operand_ld)
                cnt <= '0;
            else if (shift_en)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next  = state;
        mulreq_rdy  = 1'b0;
        mulresp_val = 1'b0;
        operand_ld  = 1'b0;
        shift_en    = 1'b0;
        add_en      = 1'b0;
        case (state)
            IDLE: begin
                mulreq_rdy = 1'b1;
                if (mulreq_val) begin
                    operand_ld = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                shift_en = 1'b1;
                add_en   = b_lsb;
                if (last_iter)
                    state_next = DONE;
            end
            DONE: begin
                mulresp_val = 1'b1;
                if (mulresp_rdy)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/imuldiv_int_mul_iter_param.sv
// Parametrised iterative shift-add multiplier (UU/SS/SU modes, 2*WIDTH product).
// Optional early termination via IMULDIV_MUL_EARLY_TERM_EN.
module imuldiv_int_mul_iter_param
    import imuldiv_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   mulreq_msg_a,
    input  logic [WIDTH-1:0]   mulreq_msg_b,
    input  logic [1:0]         mulreq_msg_mode,
    input  logic               mulreq_val,
    output logic               mulreq_rdy,
    output logic [2*WIDTH-1:0] mulresp_msg_result,
    output logic               mulresp_val,
    input  logic               mulresp_rdy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] a_reg, acc;
    logic [WIDTH-1:0]   b_reg, b_shift;
    logic               sign_reg;
    logic [64:0]        a_cond, b_cond;
    logic               operand_ld, shift_en, add_en;

    assign a_cond  = mul_operand_cond(64'(mulreq_msg_a), WIDTH, mul_a_is_signed(mulreq_msg_mode));
    assign b_cond  = mul_operand_cond(64'(mulreq_msg_b), WIDTH, mul_b_is_signed(mulreq_msg_mode));
    assign b_shift = b_reg >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            sign_reg <= 1'b0;
        end else if (operand_ld) begin
            a_reg    <= {{WIDTH{1'b0}}, a_cond[WIDTH-1:0]};
            b_reg    <= b_cond[WIDTH-1:0];
            acc      <= '0;
            sign_reg <= a_cond[64] ^ b_cond[64];
        end else if (shift_en) begin
            if (add_en)
                acc <= acc + a_reg;
            a_reg <= a_reg << 1;
            b_reg <= b_shift;
        end
    end

    assign mulresp_msg_result = sign_reg ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;

    logic [63-WIDTH:0] unused_cond;
    assign unused_cond = {a_cond[63:WIDTH] ^ b_cond[63:WIDTH]};

    imuldiv_int_mul_iter_param_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .mulreq_val  (mulreq_val),
        .mulreq_rdy  (mulreq_rdy),
        .mulresp_val (mulresp_val),
        .mulresp_rdy (mulresp_rdy),
        .b_lsb       (b_reg[0]),
        .b_next_zero (b_shift == '0),
        .operand_ld  (operand_ld),
        .shift_en    (shift_en),
        .add_en      (add_en)
    );

endmodule

// File: tb/tb_imuldiv_int_mul_iter_param.sv
// Directed bench for the iterative multiplier, 32-bit and 8-bit instances.
module tb_imuldiv_int_mul_iter_param;

`ifdef IMULDIV_MUL_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a, b;
    logic [1:0]  mode;
    logic        req_val = 1'b0, req_rdy, resp_val, resp_rdy = 1'b1;
    logic [63:0] result;

    logic [7:0]  a8, b8;
    logic [1:0]  mode8;
    logic        req_val8 = 1'b0, req_rdy8, resp_val8, resp_rdy8 = 1'b1;
    logic [15:0] result8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imuldiv_int_mul_iter_param #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .mulreq_msg_a(a), .mulreq_msg_b(b), .mulreq_msg_mode(mode),
        .mulreq_val(req_val), .mulreq_rdy(req_rdy),
        .mulresp_msg_result(result), .mulresp_val(resp_val), .mulresp_rdy(resp_rdy)
    );

    imuldiv_int_mul_iter_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .mulreq_msg_a(a8), .mulreq_msg_b(b8), .mulreq_msg_mode(mode8),
        .mulreq_val(req_val8), .mulreq_rdy(req_rdy8),
        .mulresp_msg_result(result8), .mulresp_val(resp_val8), .mulresp_rdy(resp_rdy8)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for the response; returns latency in cycles
    // counted from the accepting cycle (cycle 0).
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] im,
                         output int lat);
        int n;
        a = ia; b = ib; mode = im; req_val = 1'b1;
        n = 0;
        while (!req_rdy && n < 100) begin tick(); n++; end
        tick();
        req_val = 1'b0;
        lat = 1;
        while (!resp_val && lat < 200) begin tick(); lat++; end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [1:0] im, input logic [63:0] exp,
                          input int lat_full, input int lat_et);
        int lat;
        issue(ia, ib, im, lat);
        check({tag, "_lat"}, 128'(lat), 128'(ET ? lat_et : lat_full));
        check({tag, "_res"}, 128'(result), 128'(exp));
        tick();
        check({tag, "_idle"}, 128'(req_rdy), 128'(1));
    endtask

    initial begin
        int lat, cnt;
        a = '0; b = '0; mode = '0;
        a8 = '0; b8 = '0; mode8 = '0;
        tick(); tick();
        check("rst_rdy", 128'(req_rdy), 128'(1));
        check("rst_val", 128'(resp_val), 128'(0));
        check("rst_res", 128'(result), 128'(0));
        reset = 1'b0;

        run_op("ss_neg",   32'hFFFFFFFD, 32'h7,        2'b01, 64'hFFFFFFFFFFFFFFEB, 33, 4);
        run_op("uu_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 64'hFFFFFFFE00000001, 33, 33);
        run_op("m11_max",  32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 64'hFFFFFFFE00000001, 33, 33);
        run_op("su",       32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 64'hFFFFFFFF00000001, 33, 33);
        run_op("ss_mneg",  32'h80000000, 32'h80000000, 2'b01, 64'h4000000000000000, 33, 33);
        run_op("ss_bneg",  32'h5,        32'hFFFFFFFC, 2'b01, 64'hFFFFFFFFFFFFFFEC, 33, 4);
        run_op("uu_bzero", 32'h1234,     32'h0,        2'b00, 64'h0,                33, 2);
        run_op("uu_bone",  32'hABCD,     32'h1,        2'b00, 64'hABCD,             33, 2);

        // Response backpressure
        resp_rdy = 1'b0;
        issue(32'h3, 32'h5, 2'b00, lat);
        check("bp_lat", 128'(lat), 128'(ET ? 4 : 33));
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_val !== 1'b1 || result !== 64'd15 || req_rdy !== 1'b0) cnt++;
        end
        check("bp_stable", 128'(cnt), 128'(0));
        resp_rdy = 1'b1;
        a = 32'h9; b = 32'h9; mode = 2'b00; req_val = 1'b1;
        tick();
        check("bp_rdy_next", 128'(req_rdy), 128'(1));
        check("bp_val_drop", 128'(resp_val), 128'(0));
        tick();
        req_val = 1'b0;
        check("b2b_accept", 128'(req_rdy), 128'(0));
        lat = 1;
        while (!resp_val && lat < 200) begin tick(); lat++; end
        check("b2b_res", 128'(result), 128'(81));
        tick();

        // Reset in the middle of CALC
        a = 32'h12345; b = 32'hFFFFFFFF; mode = 2'b00; req_val = 1'b1;
        tick();
        req_val = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_rdy", 128'(req_rdy), 128'(1));
        check("mrst_val", 128'(resp_val), 128'(0));
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp_val) cnt++;
        end
        check("mrst_no_resp", 128'(cnt), 128'(0));
        run_op("after_rst", 32'h6, 32'h7, 2'b00, 64'd42, 33, 4);

        // 8-bit instance
        a8 = 8'h80; b8 = 8'hFF; mode8 = 2'b01; req_val8 = 1'b1;
        check("w8_rdy", 128'(req_rdy8), 128'(1));
        tick();
        req_val8 = 1'b0;
        lat = 1;
        while (!resp_val8 && lat < 200) begin tick(); lat++; end
        check("w8_lat", 128'(lat), 128'(ET ? 2 : 9));
        check("w8_res", 128'(result8), 128'(16'h0080));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
